// File: rtl/seq_divider.sv
// Multi-cycle restoring integer divider, one quotient bit per clock.
// Returns quotient on the ZLO half and remainder on the ZHI half of z_out.
module seq_divider #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic [2*WIDTH-1:0] z_out
);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX
    } state_t;

    state_t state, state_d;

    logic [WIDTH-1:0] rem, rem_d;
    logic [WIDTH-1:0] acc, acc_d;
    logic [WIDTH-1:0] dvs, dvs_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             q_neg, q_neg_d;
    logic             r_neg, r_neg_d;
    logic             dz, dz_d;
    logic             busy_d, done_d, dbz_d;
    logic [WIDTH-1:0] quo_d, rmd_d;

    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH:0]   rem_sh, trial;

    // Operand magnitudes and the one-bit shift/trial-subtract step
    assign dvd_neg = signed_mode & dividend[WIDTH-1];
    assign dvs_neg = signed_mode & divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? (~dividend + WIDTH'(1)) : dividend;
    assign dvs_mag = dvs_neg ? (~divisor + WIDTH'(1)) : divisor;
    assign rem_sh  = {rem, acc[WIDTH-1]};
    assign trial   = rem_sh - {1'b0, dvs};

    assign z_out = {remainder, quotient};

    // Next-state and datapath update
    always_comb begin
        state_d = state;
        rem_d   = rem;
        acc_d   = acc;
        dvs_d   = dvs;
        cnt_d   = cnt;
        q_neg_d = q_neg;
        r_neg_d = r_neg;
        dz_d    = dz;
        busy_d  = busy;
        done_d  = 1'b0;
        dbz_d   = div_by_zero;
        quo_d   = quotient;
        rmd_d   = remainder;

        case (state)
            IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    cnt_d  = '0;
                    dvs_d  = dvs_mag;
                    if (divisor == '0) begin
                        // Raw dividend is carried through unchanged as the remainder
                        dz_d    = 1'b1;
                        rem_d   = dividend;
                        acc_d   = dividend;
                        q_neg_d = 1'b0;
                        r_neg_d = 1'b0;
                        state_d = FIX;
                    end else begin
                        dz_d    = 1'b0;
                        rem_d   = '0;
                        acc_d   = dvd_mag;
                        q_neg_d = dvd_neg ^ dvs_neg;
                        r_neg_d = dvd_neg;
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    acc_d = {acc[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[WIDTH-1:0];
                    acc_d = {acc[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (dz) begin
                    quo_d = '1;
                end else begin
                    quo_d = q_neg ? (~acc + WIDTH'(1)) : acc;
                end
                rmd_d   = r_neg ? (~rem + WIDTH'(1)) : rem;
                dbz_d   = dz;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state       <= IDLE;
            rem         <= '0;
            acc         <= '0;
            dvs         <= '0;
            cnt         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dz          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else begin
            state       <= state_d;
            rem         <= rem_d;
            acc         <= acc_d;
            dvs         <= dvs_d;
            cnt         <= cnt_d;
            q_neg       <= q_neg_d;
            r_neg       <= r_neg_d;
            dz          <= dz_d;
            busy        <= busy_d;
            done        <= done_d;
            div_by_zero <= dbz_d;
            quotient    <= quo_d;
            remainder   <= rmd_d;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, control corner
// cases, and random operations against an arithmetic reference model.
module tb_seq_divider;

    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           clr;
    logic           start;
    logic           signed_mode;
    logic [W-1:0]   dividend;
    logic [W-1:0]   divisor;
    logic           busy;
    logic           done;
    logic           div_by_zero;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic [2*W-1:0] z_out;

    int checks = 0;
    int errors = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .signed_mode (signed_mode),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder),
        .z_out       (z_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         sm;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer division semantics
    function automatic void model(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == '0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (sm) begin
            q  = W'(sa / sb);
            r  = W'(sa % sb);
            dz = 1'b0;
        end else begin
            q  = a / b;
            r  = a % b;
            dz = 1'b0;
        end
    endfunction

    // Drive operands now, sample on the next edge, then scramble inputs
    task automatic capture(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
        start       = 1'b1;
        signed_mode = sm;
        dividend    = a;
        divisor     = b;
        @(posedge clk);
        #1;
        start       = 1'b0;
        signed_mode = 1'($urandom);
        dividend    = W'($urandom);
        divisor     = W'($urandom);
    endtask

    task automatic issue(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        capture(sm, a, b);
    endtask

    // Count edges until done; returns in the done cycle (1 ns after the edge)
    task automatic wait_done(input int exp_lat, input string tag);
        int  n = 0;
        bit  seen = 1'b0;
        bit  bad_busy = 1'b0;
        while (!seen && n < exp_lat + 5) begin
            @(posedge clk);
            #1;
            n++;
            if (done) begin
                seen = 1'b1;
                if (busy) bad_busy = 1'b1;
            end else if (!busy) begin
                bad_busy = 1'b1;
            end
        end
        if (seen) check({tag, " latency"}, 64'(n), 64'(exp_lat));
        else      check({tag, " done timeout"}, 64'(seen), 64'd1);
        check({tag, " busy/done"}, 64'(bad_busy), 64'd0);
    endtask

    task automatic check_results(input string tag, input logic [W-1:0] q,
                                 input logic [W-1:0] r, input logic dz);
        check({tag, " quotient"}, 64'(quotient), 64'(q));
        check({tag, " remainder"}, 64'(remainder), 64'(r));
        check({tag, " z_out"}, z_out, {r, q});
        check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(dz));
    endtask

    task automatic run(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input string tag);
        logic [W-1:0] q, r;
        logic         dz;
        model(sm, a, b, q, r, dz);
        issue(sm, a, b);
        wait_done((b == '0) ? 1 : W + 1, tag);
        check_results(tag, q, r, dz);
        @(posedge clk);
        #1;
        check({tag, " done pulse width"}, 64'(done), 64'd0);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1'b0, 32'h0000000F, 32'h00000004, 32'h00000003, 32'h00000003, 1'b0};
        vecs[1] = '{1'b1, 32'hFFFFFFF1, 32'h00000004, 32'hFFFFFFFD, 32'hFFFFFFFD, 1'b0};
        vecs[2] = '{1'b0, 32'hFFFFFFF1, 32'h00000004, 32'h3FFFFFFC, 32'h00000001, 1'b0};
        vecs[3] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};
        vecs[4] = '{1'b0, 32'h00000012, 32'h00000000, 32'hFFFFFFFF, 32'h00000012, 1'b1};
        vecs[5] = '{1'b1, 32'h0000000F, 32'hFFFFFFFC, 32'hFFFFFFFD, 32'h00000003, 1'b0};
        vecs[6] = '{1'b1, 32'hFFFFFFEC, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFEC, 1'b1};

        clr = 1'b0;
        start = 1'b0;
        signed_mode = 1'b0;
        dividend = '0;
        divisor = '0;
        #12;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check_results("reset", '0, '0, 1'b0);
        @(negedge clk);
        clr = 1'b1;

        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].sm, vecs[i].a, vecs[i].b);
            wait_done((vecs[i].b == '0) ? 1 : W + 1, $sformatf("vec%0d", i));
            check_results($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].dz);
        end

        // Start mid-operation is ignored
        issue(1'b0, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        dividend = 32'd999;
        divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(W + 1 - 6, "midstart");
        check_results("midstart", 32'd14, 32'd2, 1'b0);

        // Back-to-back: start in the done cycle, previous results held meanwhile
        capture(1'b0, 32'd50, 32'd6);
        check("b2b busy", 64'(busy), 64'd1);
        check_results("b2b hold", 32'd14, 32'd2, 1'b0);
        wait_done(W + 1, "b2b");
        check_results("b2b", 32'd8, 32'd2, 1'b0);

        // Asynchronous clear at iteration 10
        issue(1'b0, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #2;
        clr = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check_results("abort", '0, '0, 1'b0);
        begin
            bit saw = 1'b0;
            repeat (W + 4) begin
                @(posedge clk);
                #1;
                if (done) saw = 1'b1;
                if (it_release()) clr = 1'b1;
            end
            check("abort no done", 64'(saw), 64'd0);
        end
        clr = 1'b1;
        run(1'b0, 32'd100, 32'd7, "post-abort");

        // Start held high: one operation every W+2 cycles
        @(negedge clk);
        start = 1'b1;
        signed_mode = 1'b0;
        dividend = 32'd20;
        divisor = 32'd3;
        wait_done(W + 2, "held1");
        check_results("held1", 32'd6, 32'd2, 1'b0);
        wait_done(W + 2, "held2");
        start = 1'b0;
        check_results("held2", 32'd6, 32'd2, 1'b0);

        // Random operations
        for (int i = 0; i < 40; i++) begin
            logic         sm;
            logic [W-1:0] a, b;
            sm = 1'($urandom);
            a  = W'($urandom);
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 20));
                2:       b = '1;
                3:       begin a = 32'h80000000; b = W'($urandom); end
                default: b = W'($urandom) >> $urandom_range(0, 31);
            endcase
            run(sm, a, b, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Clear stays low through the observation window after an abort
    function automatic bit it_release();
        return 1'b0;
    endfunction

endmodule
